mmu_arbiter: RTL

- Shares the single SRAM/SDRAM mmu port between the instruction-fetch unit (I port) and the load/store unit (D port).
- Registers the granted request and drives the mmu request bus.
- Enforces the mmu's DONE/DR recovery, so that rw_req is never high when the mmu re-enters IDLE with a stale request.
- Returns read data and a one-cycle valid pulse to the winning requester.

---
 rtl/mmu_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mmu_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of the single mmu port.
// Define MMU_ARB_RR_EN for round-robin arbitration; default is D priority with a starvation limit.
module mmu_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_address,
  output logic [31:0]       i_read_data,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [31:0]       d_write_data,
  input  logic [1:0]        d_size,
  output logic [31:0]       d_read_data,
  output logic              d_valid,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_rw_req,
  output logic              m_rw,
  output logic [31:0]       m_write_data,
  output logic [1:0]        m_size,
  input  logic [31:0]       m_read_data,
  input  logic              m_data_valid,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;
  localparam logic [1:0] COOL  = 2'd3;

  logic [1:0] state;
  logic       grant_i;
  logic       grant_d;

`ifdef MMU_ARB_RR_EN
  // last_i remembers which port won the previous arbitration (0 = D).
  logic last_i;

  always_comb begin
    grant_i = i_req && (!d_req || !last_i);
    grant_d = d_req && (!i_req || last_i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_i <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_i)
        last_i <= 1'b1;
      else if (grant_d)
        last_i <= 1'b0;
    end
  end
`else
  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve;

  always_comb begin
    starve  = i_req && d_req && (starve_cnt == CNT_MAX);
    grant_i = i_req && (!d_req || starve);
    grant_d = d_req && !starve;
  end

  // Counts D wins while I is waiting; never exceeds CNT_MAX because I wins there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!i_req) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_i)
        starve_cnt <= '0;
      else if (grant_d)
        starve_cnt <= starve_cnt + CNT_ONE;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      i_read_data  <= '0;
      i_valid      <= 1'b0;
      d_read_data  <= '0;
      d_valid      <= 1'b0;
      m_address    <= '0;
      m_rw_req     <= 1'b0;
      m_rw         <= 1'b0;
      m_write_data <= '0;
      m_size       <= '0;
      busy         <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i) begin
            m_address    <= i_address;
            m_rw         <= 1'b0;
            m_size       <= 2'd2;
            m_write_data <= '0;
            m_rw_req     <= 1'b1;
            busy         <= 1'b1;
            state        <= GNT_I;
          end else if (grant_d) begin
            m_address    <= d_address;
            m_rw         <= d_rw;
            m_size       <= d_size;
            m_write_data <= d_write_data;
            m_rw_req     <= 1'b1;
            busy         <= 1'b1;
            state        <= GNT_D;
          end
        end
        GNT_I: begin
          if (m_data_valid) begin
            i_read_data <= m_read_data;
            i_valid     <= 1'b1;
            m_rw_req    <= 1'b0;
            state       <= COOL;
          end
        end
        GNT_D: begin
          if (m_data_valid) begin
            d_read_data <= m_read_data;
            d_valid     <= 1'b1;
            m_rw_req    <= 1'b0;
            state       <= COOL;
          end
        end
        // One idle cycle while the mmu sits in DR, so no request is seen on its return to IDLE.
        COOL: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          m_rw_req <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
